// File: rtl/amo_pkg.sv
// Shared definitions for the AMO sequencer: ALU one-hot opcodes, FSM states,
// and the legality check for incoming atomic requests.
package amo_pkg;

   localparam logic [19:0] AMO_SWAP = 20'd8192;
   localparam logic [19:0] AMO_ADD  = 20'd16384;
   localparam logic [19:0] AMO_AND  = 20'd32768;
   localparam logic [19:0] AMO_OR   = 20'd65536;
   localparam logic [19:0] AMO_XOR  = 20'd131072;
   localparam logic [19:0] AMO_MAX  = 20'd262144;
   localparam logic [19:0] AMO_MIN  = 20'd524288;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CALC,
      ST_WR,
      ST_RESP
   } amo_state_e;

   // Only these exact one-hot codes are atomics; any other bit pattern is illegal.
   function automatic logic is_legal_amo(input logic [19:0] op);
      case (op)
         AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
         AMO_XOR, AMO_MAX, AMO_MIN: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/amo_ack_timer.sv
// Counts cycles a memory request has waited for its acknowledge; flags expiry
// in the cycle the wait reaches ACK_TIMEOUT. ACK_TIMEOUT=0 never expires.
module amo_ack_timer #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam int LAST_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   logic [CW-1:0] cnt_q;

   // Saturates at LAST so a disabled or stalled counter never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (ACK_TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/amo_sequencer.sv
// Runs one RISC-V atomic read-modify-write: read old word, let the ALU combine
// it with rs2, write the result back, return the old word.
module amo_sequencer
   import amo_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [19:0] amo_op,
   input  logic [31:0] addr,
   input  logic [31:0] rs2_val,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] rd_val,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [19:0] alu_instr,
   input  logic [63:0] alu_result
);

   amo_state_e  state_q;
   logic [19:0] op_q;
   logic [31:0] addr_q;
   logic [31:0] rs2_q;
   logic [31:0] old_q;
   logic [31:0] new_q;
   logic        busy_q, done_q, error_q;
   logic [31:0] rd_val_q;
   logic        mem_req_q, mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] alu_in1_q, alu_in2_q;
   logic [19:0] alu_instr_q;

   logic        tmr_clr, tmr_en, tmr_expired;
   logic [31:0] unused_alu_hi;

   assign unused_alu_hi = alu_result[63:32];

   // The counter is zero whenever RD or WR is entered, since both are only
   // reached from IDLE or CALC.
   assign tmr_clr = (state_q == ST_IDLE) || (state_q == ST_CALC);
   assign tmr_en  = (state_q == ST_RD)   || (state_q == ST_WR);

   amo_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         rs2_q       <= '0;
         old_q       <= '0;
         new_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rd_val_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_instr_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q   <= amo_op;
                  addr_q <= addr;
                  rs2_q  <= rs2_val;
                  old_q  <= '0;
                  busy_q <= 1'b1;
                  if (!is_legal_amo(amo_op) || (addr[1:0] != 2'b00)) begin
                     state_q  <= ST_RESP;
                     done_q   <= 1'b1;
                     error_q  <= 1'b1;
                     rd_val_q <= '0;
                  end else begin
                     state_q    <= ST_RD;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= addr;
                  end
               end
            end
            ST_RD: begin
               // An ack coinciding with expiry still completes the read.
               if (mem_ack) begin
                  state_q     <= ST_CALC;
                  old_q       <= mem_rdata;
                  mem_req_q   <= 1'b0;
                  alu_in1_q   <= mem_rdata;
                  alu_in2_q   <= rs2_q;
                  alu_instr_q <= op_q;
               end else if (tmr_expired) begin
                  state_q   <= ST_RESP;
                  mem_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  error_q   <= 1'b1;
                  rd_val_q  <= '0;
               end
            end
            ST_CALC: begin
               state_q     <= ST_WR;
               new_q       <= alu_result[31:0];
               alu_in1_q   <= '0;
               alu_in2_q   <= '0;
               alu_instr_q <= '0;
               mem_req_q   <= 1'b1;
               mem_we_q    <= 1'b1;
               mem_addr_q  <= addr_q;
            end
            ST_WR: begin
               if (mem_ack || tmr_expired) begin
                  state_q   <= ST_RESP;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  done_q    <= 1'b1;
                  error_q   <= !mem_ack;
                  rd_val_q  <= mem_ack ? old_q : '0;
               end
            end
            ST_RESP: begin
               state_q  <= ST_IDLE;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               error_q  <= 1'b0;
               rd_val_q <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign rd_val    = rd_val_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = new_q;
   assign alu_in1   = alu_in1_q;
   assign alu_in2   = alu_in2_q;
   assign alu_instr = alu_instr_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer with a behavioural memory and ALU model.
module tb_amo_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [19:0] amo_op = '0;
   logic [31:0] addr = '0;
   logic [31:0] rs2_val = '0;
   logic        busy, done, error;
   logic [31:0] rd_val;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] alu_in1, alu_in2;
   logic [19:0] alu_instr;
   logic [63:0] alu_result;
   logic [31:0] alu_lo;

   amo_sequencer #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amo_op(amo_op), .addr(addr),
      .rs2_val(rs2_val), .busy(busy), .done(done), .error(error), .rd_val(rd_val),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_instr(alu_instr), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Reference ALU: unsigned MAX/MIN, junk in the upper half that must be ignored.
   always_comb begin
      alu_lo = '0;
      case (alu_instr)
         20'd8192:   alu_lo = alu_in2;
         20'd16384:  alu_lo = alu_in1 + alu_in2;
         20'd32768:  alu_lo = alu_in1 & alu_in2;
         20'd65536:  alu_lo = alu_in1 | alu_in2;
         20'd131072: alu_lo = alu_in1 ^ alu_in2;
         20'd262144: alu_lo = (alu_in1 > alu_in2) ? alu_in1 : alu_in2;
         20'd524288: alu_lo = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
         default:    alu_lo = '0;
      endcase
   end
   assign alu_result = {32'hA5A5_A5A5, alu_lo};

   int vec = 0;
   int mis = 0;

   logic [31:0] mem [logic [31:0]];
   int  ack_delay = 0;
   bit  no_ack = 1'b0;
   bit  hold_wr = 1'b0;
   int  req_cycles = 0;
   int  wr_cnt = 0;
   int  done_cnt = 0;
   int  stab_err = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_wr_addr = '0;

   task automatic responder();
      int wait_cnt = 0;
      logic [31:0] s_addr = '0, s_wdata = '0;
      logic s_we = 1'b0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         mem_ack = 1'b0;
         if (mem_req) begin
            req_cycles++;
            if (wait_cnt == 0) begin
               s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
            end else if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
               stab_err++;
            end
            if (!no_ack && !(hold_wr && mem_we) && wait_cnt == ack_delay) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  wr_cnt++;
                  last_wr_addr = mem_addr;
               end else begin
                  mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                  last_rd_addr = mem_addr;
               end
            end
            wait_cnt++;
         end else begin
            wait_cnt = 0;
         end
      end
   endtask

   // Issues one request; lat counts cycles from the IDLE sample cycle to done, inclusive.
   task automatic run_op(input logic [19:0] op, input logic [31:0] a, input logic [31:0] r,
                         output logic [31:0] rd, output logic er, output int lat);
      bit got = 1'b0;
      @(negedge clk);
      start = 1'b1; amo_op = op; addr = a; rs2_val = r;
      @(posedge clk);
      lat = 1; rd = '0; er = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (done) begin got = 1'b1; rd = rd_val; er = error; end
      end
      if (!got) begin
         vec++; mis++;
         $display("FAIL done_wait: no done within 40 cycles for op %0d addr %h", op, a);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      vec++;
      if ({busy, done, error, rd_val, mem_req, mem_we, mem_addr, mem_wdata,
           alu_in1, alu_in2, alu_instr} !== '0) begin
         mis++; $display("FAIL reset_outputs: some output nonzero, rd_val=%h mem_req=%b", rd_val, mem_req);
      end
      vec++;
      if (busy !== 1'b0) begin mis++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if (mem_req !== 1'b0) begin mis++; $display("FAIL idle_req: got %b want 0", mem_req); end
   endtask

   task automatic test_add();
      logic [31:0] rd; logic er; int lat; int w0;
      mem[32'h100] = 32'd5; ack_delay = 0; w0 = wr_cnt;
      run_op(20'd16384, 32'h100, 32'd3, rd, er, lat);
      vec++; if (rd !== 32'd5) begin mis++; $display("FAIL add_rd: got %h want 5", rd); end
      vec++; if (er !== 1'b0) begin mis++; $display("FAIL add_err: got %b want 0", er); end
      vec++; if (lat != 5) begin mis++; $display("FAIL add_latency: got %0d want 5", lat); end
      vec++; if (last_rd_addr !== 32'h100) begin mis++; $display("FAIL add_rd_addr: got %h want 100", last_rd_addr); end
      vec++; if (last_wr_addr !== 32'h100) begin mis++; $display("FAIL add_wr_addr: got %h want 100", last_wr_addr); end
      vec++; if (mem[32'h100] !== 32'd8) begin mis++; $display("FAIL add_wdata: got %h want 8", mem[32'h100]); end
      vec++; if (wr_cnt - w0 != 1) begin mis++; $display("FAIL add_wr_count: got %0d want 1", wr_cnt - w0); end
      @(negedge clk);
      vec++; if (done !== 1'b0 || busy !== 1'b0) begin
         mis++; $display("FAIL add_done_pulse: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_swap_wait();
      logic [31:0] rd; logic er; int lat; int rc0, se0;
      mem[32'h200] = 32'hDEADBEEF; ack_delay = 2; rc0 = req_cycles; se0 = stab_err;
      run_op(20'd8192, 32'h200, 32'h12345678, rd, er, lat);
      vec++; if (rd !== 32'hDEADBEEF) begin mis++; $display("FAIL swap_rd: got %h want deadbeef", rd); end
      vec++; if (er !== 1'b0) begin mis++; $display("FAIL swap_err: got %b want 0", er); end
      vec++; if (mem[32'h200] !== 32'h12345678) begin mis++; $display("FAIL swap_wdata: got %h want 12345678", mem[32'h200]); end
      vec++; if (stab_err != se0) begin mis++; $display("FAIL swap_stable: %0d unstable cycles want 0", stab_err - se0); end
      vec++; if (req_cycles - rc0 != 6) begin mis++; $display("FAIL swap_req_cycles: got %0d want 6", req_cycles - rc0); end
      vec++; if (lat != 9) begin mis++; $display("FAIL swap_latency: got %0d want 9", lat); end
      ack_delay = 0;
   endtask

   task automatic test_illegal();
      logic [31:0] rd; logic er; int lat; int rc0;
      mem[32'h104] = 32'h11; mem[32'h100] = 32'h22;
      rc0 = req_cycles;
      run_op(20'd1, 32'h104, 32'd1, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin mis++; $display("FAIL illegal_op: err=%b rd=%h want 1 0", er, rd); end
      vec++; if (lat != 2) begin mis++; $display("FAIL illegal_latency: got %0d want 2", lat); end
      run_op(20'd8192, 32'h102, 32'd1, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin mis++; $display("FAIL misaligned: err=%b rd=%h want 1 0", er, rd); end
      run_op(20'd24576, 32'h100, 32'd1, rd, er, lat);
      vec++; if (er !== 1'b1) begin mis++; $display("FAIL two_hot_op: err=%b want 1", er); end
      vec++; if (req_cycles != rc0) begin mis++; $display("FAIL illegal_no_req: got %0d req cycles want 0", req_cycles - rc0); end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; logic er; int lat; int rc0, w0;
      mem[32'h400] = 32'd7; no_ack = 1'b1; rc0 = req_cycles; w0 = wr_cnt;
      run_op(20'd16384, 32'h400, 32'd1, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin mis++; $display("FAIL timeout_resp: err=%b rd=%h want 1 0", er, rd); end
      vec++; if (req_cycles - rc0 != 4) begin mis++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles - rc0); end
      vec++; if (wr_cnt != w0 || mem[32'h400] !== 32'd7) begin mis++; $display("FAIL timeout_no_write: writes=%0d mem=%h want 0 7", wr_cnt - w0, mem[32'h400]); end
      no_ack = 1'b0; ack_delay = 3;
      mem[32'h404] = 32'd10; rc0 = req_cycles;
      run_op(20'd16384, 32'h404, 32'd5, rd, er, lat);
      vec++; if (er !== 1'b0 || rd !== 32'd10) begin mis++; $display("FAIL ack_on_limit: err=%b rd=%h want 0 a", er, rd); end
      vec++; if (mem[32'h404] !== 32'd15) begin mis++; $display("FAIL ack_on_limit_wdata: got %h want f", mem[32'h404]); end
      vec++; if (req_cycles - rc0 != 8) begin mis++; $display("FAIL ack_on_limit_req: got %0d want 8", req_cycles - rc0); end
      ack_delay = 0;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0; int w0, d0;
      mem[32'h500] = 32'd1; hold_wr = 1'b1; w0 = wr_cnt; d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; amo_op = 20'd16384; addr = 32'h500; rs2_val = 32'd1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_req && mem_we) seen = 1'b1;
      end
      vec++; if (!seen) begin mis++; $display("FAIL rst_mid_reach_wr: write phase not reached"); end
      #2 rst_n = 1'b0;
      #1;
      vec++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
         mis++; $display("FAIL rst_mid_async: mem_req=%b busy=%b want 0 0", mem_req, busy);
      end
      @(negedge clk); rst_n = 1'b1; hold_wr = 1'b0;
      repeat (4) @(negedge clk);
      vec++; if (done_cnt != d0 || wr_cnt != w0 || mem[32'h500] !== 32'd1) begin
         mis++; $display("FAIL rst_mid_quiet: dones=%0d writes=%0d want 0 0", done_cnt - d0, wr_cnt - w0);
      end
   endtask

   task automatic test_start_held();
      bit got; int d0;
      mem[32'h600] = 32'd2; d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; amo_op = 20'd16384; addr = 32'h600; rs2_val = 32'd1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (done) got = 1'b1; end
      start = 1'b0;
      repeat (8) @(negedge clk);
      vec++; if (!got || done_cnt - d0 != 1 || mem[32'h600] !== 32'd3) begin
         mis++; $display("FAIL held_single: dones=%0d mem=%h want 1 3", done_cnt - d0, mem[32'h600]);
      end
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (done) got = 1'b1; end
      @(negedge clk);
      vec++; if (busy !== 1'b0) begin mis++; $display("FAIL held_idle_gap: busy=%b want 0", busy); end
      @(negedge clk);
      start = 1'b0;
      vec++; if (busy !== 1'b1) begin mis++; $display("FAIL held_reaccept: busy=%b want 1", busy); end
      repeat (10) @(negedge clk);
      vec++; if (done_cnt - d0 != 2 || mem[32'h600] !== 32'd5) begin
         mis++; $display("FAIL held_second: dones=%0d mem=%h want 2 5", done_cnt - d0, mem[32'h600]);
      end
   endtask

   task automatic test_maxmin();
      logic [31:0] rd; logic er; int lat;
      mem[32'h300] = 32'h80000000; mem[32'h304] = 32'h80000000;
      run_op(20'd262144, 32'h300, 32'd1, rd, er, lat);
      vec++; if (mem[32'h300] !== 32'h80000000 || rd !== 32'h80000000 || er !== 1'b0) begin
         mis++; $display("FAIL max_unsigned: mem=%h rd=%h want 80000000 80000000", mem[32'h300], rd);
      end
      run_op(20'd524288, 32'h304, 32'd1, rd, er, lat);
      vec++; if (mem[32'h304] !== 32'd1 || rd !== 32'h80000000) begin
         mis++; $display("FAIL min_unsigned: mem=%h rd=%h want 1 80000000", mem[32'h304], rd);
      end
      run_op(20'd131072, 32'h304, 32'h0000_00FF, rd, er, lat);
      vec++; if (mem[32'h304] !== 32'h0000_00FE || rd !== 32'd1) begin
         mis++; $display("FAIL xor: mem=%h rd=%h want fe 1", mem[32'h304], rd);
      end
   endtask

   initial begin
      fork
         responder();
      join_none
      test_reset();
      test_add();
      test_swap_wait();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_start_held();
      test_maxmin();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Executes one RISC-V A-extension read-modify-write at a time.
- Sequence: read the old word from memory; present old word and rs2 to the execute ALU using the ALU's one-hot 20-bit opcode; write the ALU result back; return the old word for rd.
- Sits between the execute stage and the data-memory port, wrapped around the ALU: it feeds the ALU's operands and consumes its output.

Parameters:
- ACK_TIMEOUT, 255, max cycles a memory request waits for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- amo_op  in  20  one-hot ALU opcode: 8192 SWAP, 16384 ADD, 32768 AND, 65536 OR, 131072 XOR, 262144 MAX, 524288 MIN.
- addr  in  32  word address of the atomic.
- rs2_val  in  32  source operand.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done: illegal op, misaligned address, or timeout.
- rd_val  out  32  old memory word; valid with done; 0 on error.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack on a read.
- mem_ack  in  1  acknowledge; counted only while mem_req=1.
- alu_in1  out  32  to ALU in1 (old word).
- alu_in2  out  32  to ALU in2 (rs2).
- alu_instr  out  20  to ALU opcode; 0 outside CALC.
- alu_result  in  64  from ALU; only bits [31:0] are used.

Behaviour:
- Reset: every output is 0. State goes to IDLE and all latches clear.
- Reset mid-operation: mem_req drops asynchronously. No write is issued and no done is produced.
- States: IDLE, RD, CALC, WR, RESP.
- IDLE, start=1:
  - Latch amo_op, addr and rs2_val.
  - amo_op not exactly one of the seven legal codes, or addr[1:0] != 0: go to RESP with error=1 and no memory traffic.
  - Otherwise go to RD.
- IDLE, start=0: stay. start in any other state is ignored and is not queued.
- RD:
  - mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: capture mem_rdata into old_val and go to CALC.
  - An ack in the first RD cycle is legal, giving a 1-cycle read.
- CALC (exactly one cycle):
  - alu_in1=old_val, alu_in2=rs2, alu_instr=op.
  - Register alu_result[31:0] into new_val, then go to WR.
  - MAX/MIN take the ALU's comparison result unmodified; the sequencer does no re-signing.
- WR:
  - mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=new_val.
  - On mem_ack go to RESP.
- RESP:
  - done=1 for exactly one cycle.
  - rd_val=old_val, or 0 if error; error as latched.
  - Next state is IDLE, so a new start is accepted the cycle after done.
- mem_addr, mem_we and mem_wdata hold stable while mem_req=1. In IDLE, CALC and RESP: mem_req=0, mem_we=0.
- Timeout counter:
  - Clears on entry to RD or WR and increments each waiting cycle.
  - On reaching ACK_TIMEOUT (when nonzero): deassert mem_req, go to RESP with error=1.
  - A timeout in RD means no write is issued. A timeout in WR means memory may be written late; error is still flagged.
  - An ack arriving in the same cycle as the timeout wins.
- Latency, zero-wait-state memory: start to done = 5 cycles (RD, CALC, WR, RESP, plus the IDLE sample).

Decomposition:
- Package amo_pkg holds:
  - the seven one-hot AMO opcode localparams, the same values as the ALU opcode table;
  - the state encoding;
  - a function is_legal_amo(op) returning 1 for exactly those seven values.
- Sub-module amo_ack_timer: the cycle counter with clear/enable/expired, parameterised by ACK_TIMEOUT. Everything else is flat.

Test Plan:
- ADD, zero-wait memory: mem[0x100]=5, rs2=3, op=16384 → reads 0x100, writes 8, rd_val=5, done 5 cycles after start, error=0.
- SWAP with 3-cycle ack delays: mem[0x200]=0xDEADBEEF, rs2=0x12345678 → mem_req, mem_addr and mem_we held stable while waiting; write 0x12345678; rd_val=0xDEADBEEF.
- Illegal op and misaligned address:
  - op=1 → done+error with rd_val=0 and no mem_req ever.
  - addr=0x102 with a legal op → the same response.
- Timeout, ACK_TIMEOUT=4, no ack in RD → mem_req drops after 4 cycles, done+error, no write; ack arriving on cycle 4 → completes normally.
- Reset and start-while-busy:
  - rst_n low during WR → mem_req=0 at once, no done.
  - After reset, start held high through a whole operation → exactly one operation runs, done pulses once; a second request is accepted only if start is still high in IDLE.
- MAX/MIN: old=0x80000000, rs2=1, op=262144 → writes 0x80000000 (unsigned ALU compare); op=524288 → writes 1.
